cam_i2c_config: RTL and testbench

- Camera sensor register loader, downstream of the staged reset-release generator.
- Held in reset by one of that generator's staggered reset outputs. After release, walks an external register LUT and writes every entry to the sensor over a single-master I2C bus.
- Reports completion or ACK failure to the capture pipeline, which must not start framing until CONFIG_DONE=1.

---
 rtl/cam_i2c_config_if.sv | 27 ++
 rtl/cam_i2c_config.sv | 192 +++++++++++++++++++
 tb/tb_cam_i2c_config.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cam_i2c_config_if.sv
// rtl/cam_i2c_config_if.sv - control/status and LUT port bundle for the camera register loader
interface cam_i2c_config_if;
    logic        START;
    logic [23:0] LUT_DATA;
    logic [5:0]  LUT_INDEX;
    logic        BUSY;
    logic        CONFIG_DONE;
    logic        ACK_ERR;

    modport master (
        output START,
        output LUT_DATA,
        input  LUT_INDEX,
        input  BUSY,
        input  CONFIG_DONE,
        input  ACK_ERR
    );

    modport slave (
        input  START,
        input  LUT_DATA,
        output LUT_INDEX,
        output BUSY,
        output CONFIG_DONE,
        output ACK_ERR
    );
endinterface

// File: rtl/cam_i2c_config.sv
// rtl/cam_i2c_config.sv - walks a register LUT and writes each entry to a camera sensor over I2C
module cam_i2c_config #(
    parameter int         QTR_DIV   = 125,
    parameter int         NUM_REGS  = 24,
    parameter logic [7:0] DEV_ADDR  = 8'hBA,
    parameter int         MAX_RETRY = 3
) (
    input  logic              CLK,
    input  logic              RST,
    cam_i2c_config_if.slave   cfg,
    output logic              I2C_SCLK,
    inout  wire               I2C_SDAT
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {IDLE, START_C, BIT, ACK, STOP_C, GAP, DONE, ERR} state_t;

    state_t          state_q;
    logic [1:0]      qcnt_q;
    logic [2:0]      bitcnt_q;
    logic [1:0]      bytecnt_q;
    logic [31:0]     shreg_q;
    logic [RW-1:0]   retry_q;
    logic            nack_q;
    logic [15:0]     div_q, div_d;
    logic            scl_q;
    logic            sda_low_q;
    logic [5:0]      idx_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            auto_q;
    logic            sda_meta_q, sda_sync_q;
    logic            qtick;

    assign qtick = busy_q && (div_q == 16'(QTR_DIV - 1));

    always_comb begin
        div_d = '0;
        if (busy_q && !qtick) begin
            div_d = div_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            qcnt_q     <= '0;
            bitcnt_q   <= '0;
            bytecnt_q  <= '0;
            shreg_q    <= '0;
            retry_q    <= '0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            auto_q     <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
        end else begin
            sda_meta_q <= I2C_SDAT;
            sda_sync_q <= sda_meta_q;
            case (state_q)
                IDLE, DONE, ERR: begin
                    // The first run after reset needs no START pulse.
                    if (auto_q || cfg.START) begin
                        auto_q    <= 1'b0;
                        idx_q     <= '0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        retry_q   <= '0;
                        nack_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        qcnt_q    <= '0;
                        scl_q     <= 1'b1;
                        sda_low_q <= 1'b0;
                        state_q   <= START_C;
                    end
                end
                START_C: if (qtick) begin
                    if (qcnt_q == 2'd0) begin
                        // LUT_INDEX has settled by now, so the entry is captured here.
                        qcnt_q    <= 2'd1;
                        sda_low_q <= 1'b1;
                        shreg_q   <= {DEV_ADDR, cfg.LUT_DATA};
                    end else begin
                        qcnt_q    <= '0;
                        bitcnt_q  <= '0;
                        bytecnt_q <= '0;
                        scl_q     <= 1'b0;
                        sda_low_q <= ~shreg_q[31];
                        state_q   <= BIT;
                    end
                end
                BIT: if (qtick) begin
                    qcnt_q <= qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd1: scl_q <= 1'b1;
                        2'd3: begin
                            scl_q   <= 1'b0;
                            shreg_q <= {shreg_q[30:0], 1'b0};
                            if (bitcnt_q == 3'd7) begin
                                sda_low_q <= 1'b0;
                                state_q   <= ACK;
                            end else begin
                                bitcnt_q  <= bitcnt_q + 3'd1;
                                sda_low_q <= ~shreg_q[30];
                            end
                        end
                        default: ;
                    endcase
                end
                ACK: if (qtick) begin
                    qcnt_q <= qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd1: scl_q <= 1'b1;
                        2'd3: begin
                            scl_q <= 1'b0;
                            if (sda_sync_q || bytecnt_q == 2'd3) begin
                                nack_q    <= sda_sync_q;
                                sda_low_q <= 1'b1;
                                state_q   <= STOP_C;
                            end else begin
                                bytecnt_q <= bytecnt_q + 2'd1;
                                bitcnt_q  <= '0;
                                sda_low_q <= ~shreg_q[31];
                                state_q   <= BIT;
                            end
                        end
                        default: ;
                    endcase
                end
                STOP_C: if (qtick) begin
                    qcnt_q <= qcnt_q + 2'd1;
                    case (qcnt_q)
                        2'd0: scl_q <= 1'b1;
                        2'd1: sda_low_q <= 1'b0;
                        default: begin
                            qcnt_q  <= '0;
                            state_q <= GAP;
                        end
                    endcase
                end
                GAP: if (qtick) begin
                    qcnt_q <= qcnt_q + 2'd1;
                    if (qcnt_q == 2'd3) begin
                        if (nack_q) begin
                            if (retry_q != RW'(MAX_RETRY)) begin
                                retry_q <= retry_q + 1'b1;
                                nack_q  <= 1'b0;
                                state_q <= START_C;
                            end else begin
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                                state_q <= ERR;
                            end
                        end else if (idx_q == 6'(NUM_REGS - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            idx_q   <= idx_q + 6'd1;
                            retry_q <= '0;
                            state_q <= START_C;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign I2C_SCLK        = scl_q;
    assign I2C_SDAT        = sda_low_q ? 1'b0 : 1'bz;
    assign cfg.LUT_INDEX   = idx_q;
    assign cfg.BUSY        = busy_q;
    assign cfg.CONFIG_DONE = done_q;
    assign cfg.ACK_ERR     = err_q;

endmodule

// File: tb/tb_cam_i2c_config.sv
// tb/tb_cam_i2c_config.sv - scoreboard bench: I2C slave/decoder checks frames, timing and status
module tb_cam_i2c_config;
    localparam int QTR  = 2;
    localparam int NREG = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl;
    wire  sda;
    logic slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    cam_i2c_config_if cfg();

    cam_i2c_config #(
        .QTR_DIV(QTR), .NUM_REGS(NREG), .DEV_ADDR(8'hBA), .MAX_RETRY(3)
    ) dut (
        .CLK(clk), .RST(rst_n), .cfg(cfg.slave), .I2C_SCLK(scl), .I2C_SDAT(sda)
    );

    always #5 clk = ~clk;

    logic [23:0] lut [4];
    assign cfg.LUT_DATA = lut[cfg.LUT_INDEX[1:0]];

    int n_vec = 0;
    int n_miss = 0;
    logic [7:0] exp_bytes [$];
    int exp_len [$];
    int mode = 0;
    bit nacked_once = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic viol(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_frame(input int idx, input int nb);
        logic [31:0] w;
        w = {8'hBA, lut[idx]};
        for (int i = 0; i < nb; i++) exp_bytes.push_back(w[31 - 8*i -: 8]);
        exp_len.push_back(nb);
    endtask

    task automatic push_run();
        for (int i = 0; i < NREG; i++) push_frame(i, 4);
    endtask

    task automatic pulse_start();
        cfg.START = 1'b1;
        @(negedge clk);
        cfg.START = 1'b0;
    endtask

    task automatic run_len(output int n);
        n = 0;
        while (cfg.BUSY && n < 4000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Slave model and frame decoder; pops the scoreboard as bytes and STOPs appear.
    initial begin
        logic scl_p, sda_p, nack;
        logic [7:0] sh, cur_reg;
        int bitcnt, bytepos;
        bit in_frame;
        scl_p = 1'b1; sda_p = 1'b1; sh = '0; cur_reg = '0;
        bitcnt = 0; bytepos = 0; in_frame = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                scl_p = 1'b1; sda_p = 1'b1; bitcnt = 0; bytepos = 0;
                in_frame = 1'b0; slave_low = 1'b0;
            end else begin
                if (slave_low && sda !== 1'b0) viol("sda_not_low_while_slave_drives");
                if (scl_p && scl && sda !== sda_p) begin
                    if (sda === 1'b0) begin
                        if (in_frame) viol("start_inside_frame");
                        in_frame = 1'b1; bitcnt = 0; bytepos = 0;
                    end else begin
                        if (!in_frame || bitcnt != 1) viol("sda_change_while_scl_high");
                        else if (exp_len.size() == 0) viol("unexpected_stop");
                        else check("frame_len", bytepos, exp_len.pop_front());
                        in_frame = 1'b0; bitcnt = 0;
                    end
                end else if (!scl_p && scl && in_frame) begin
                    if (bitcnt < 8) sh = {sh[6:0], sda};
                    bitcnt++;
                end else if (scl_p && !scl && in_frame) begin
                    if (bitcnt == 8) begin
                        if (exp_bytes.size() == 0) viol("unexpected_byte");
                        else check("frame_byte", sh, exp_bytes.pop_front());
                        if (bytepos == 1) cur_reg = sh;
                        nack = 1'b0;
                        if (mode == 2 && bytepos == 0) nack = 1'b1;
                        if (mode == 1 && bytepos == 2 && cur_reg == lut[1][23:16] && !nacked_once) begin
                            nack = 1'b1;
                            nacked_once = 1'b1;
                        end
                        slave_low = !nack;
                        bytepos++;
                    end else if (bitcnt == 9) begin
                        slave_low = 1'b0;
                        bitcnt = 0;
                    end
                end
                scl_p = scl;
                sda_p = sda;
            end
        end
    end

    initial begin
        int n;
        lut[0] = 24'h12_3456;
        lut[1] = 24'h34_A5C3;
        lut[2] = 24'hFE_0180;
        lut[3] = 24'h00_0000;
        cfg.START = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", cfg.BUSY, 0);
        check("rst_done", cfg.CONFIG_DONE, 0);
        check("rst_err", cfg.ACK_ERR, 0);
        check("rst_index", cfg.LUT_INDEX, 0);

        // Auto-run after reset release, every entry ACKed.
        mode = 0;
        push_run();
        rst_n = 1'b1;
        @(negedge clk);
        check("autostart_busy", cfg.BUSY, 1);
        check("autostart_index", cfg.LUT_INDEX, 0);
        run_len(n);
        check("run_cycles_ack_all", n, 918);
        check("done_ack_all", cfg.CONFIG_DONE, 1);
        check("err_ack_all", cfg.ACK_ERR, 0);
        check("index_at_done", cfg.LUT_INDEX, NREG - 1);

        // START after DONE, with a second START mid-run that must be ignored.
        push_run();
        pulse_start();
        check("restart_done_cleared", cfg.CONFIG_DONE, 0);
        check("restart_busy", cfg.BUSY, 1);
        check("restart_index", cfg.LUT_INDEX, 0);
        n = 0;
        while (cfg.BUSY && n < 4000) begin
            cfg.START = (n == 100);
            @(negedge clk);
            n++;
        end
        cfg.START = 1'b0;
        check("run_cycles_restart", n, 918);
        check("done_restart", cfg.CONFIG_DONE, 1);
        repeat (20) @(negedge clk);
        check("no_second_run", cfg.BUSY, 0);

        // Entry 1 NACKed once on data_hi, then re-sent in full.
        mode = 1;
        nacked_once = 1'b0;
        push_frame(0, 4);
        push_frame(1, 3);
        push_frame(1, 4);
        push_frame(2, 4);
        pulse_start();
        run_len(n);
        check("run_cycles_one_retry", n, 1152);
        check("done_one_retry", cfg.CONFIG_DONE, 1);
        check("err_one_retry", cfg.ACK_ERR, 0);

        // Address byte always NACKed: 1 + MAX_RETRY attempts then abort.
        mode = 2;
        for (int i = 0; i < 4; i++) push_frame(0, 1);
        pulse_start();
        run_len(n);
        check("run_cycles_abort", n, 360);
        check("err_abort", cfg.ACK_ERR, 1);
        check("done_abort", cfg.CONFIG_DONE, 0);
        check("index_abort", cfg.LUT_INDEX, 0);

        // Reset in the middle of entry 2, then auto-run from index 0.
        mode = 0;
        push_run();
        pulse_start();
        check("err_cleared_by_start", cfg.ACK_ERR, 0);
        n = 0;
        while (cfg.LUT_INDEX != 6'd2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reached_entry2", cfg.LUT_INDEX, 2);
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda, 1);
        check("midrst_busy", cfg.BUSY, 0);
        exp_bytes.delete();
        exp_len.delete();
        repeat (3) @(negedge clk);
        push_run();
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun_busy", cfg.BUSY, 1);
        check("rerun_index", cfg.LUT_INDEX, 0);
        run_len(n);
        check("run_cycles_after_rst", n, 918);
        check("done_after_rst", cfg.CONFIG_DONE, 1);

        repeat (5) @(negedge clk);
        check("bytes_drained", exp_bytes.size(), 0);
        check("frames_drained", exp_len.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
